// File: rtl/mem_arbiter.sv
// mem_arbiter
// -----------------------------------------------------------------------------
// Two-requester arbiter and sequencer in front of a single-port synchronous
// sample RAM. The RAM has a 1-cycle registered read and returns old data on a
// read-during-write. Port 0 is the capture side and port 1 is the
// playback/CPU side.
//
// At most one access is granted per cycle. The granted port's we/addr/wdata
// are driven to the RAM. A returning read word is steered to the port that
// issued the read, one cycle after the grant.
//
// Configuration macro:
//   MEM_ARBITER_FIXED_PRIO_EN - when defined, port 0 always wins a conflict
//                               and no round-robin pointer exists. When
//                               undefined (default), round-robin arbitration.
//
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   mX_req/we/addr/wdata       request side of port X (held until mX_gnt)
//   mX_gnt                     combinational accept for port X
//   mX_rvalid/rdata            read return for port X (rdata is 0 when idle)
//   mem_we/a/din               drive to the RAM
//   mem_dout                   read data from the RAM
// -----------------------------------------------------------------------------
module mem_arbiter #(
    parameter  int WORD_SIZE = 24,
    parameter  int N_WORDS   = 512,
    localparam int ADDR_W    = $clog2(N_WORDS)
) (
    input  logic                 clk,
    input  logic                 rst_n,

    input  logic                 m0_req,
    input  logic                 m0_we,
    input  logic [ADDR_W-1:0]    m0_addr,
    input  logic [WORD_SIZE-1:0] m0_wdata,
    output logic                 m0_gnt,
    output logic                 m0_rvalid,
    output logic [WORD_SIZE-1:0] m0_rdata,

    input  logic                 m1_req,
    input  logic                 m1_we,
    input  logic [ADDR_W-1:0]    m1_addr,
    input  logic [WORD_SIZE-1:0] m1_wdata,
    output logic                 m1_gnt,
    output logic                 m1_rvalid,
    output logic [WORD_SIZE-1:0] m1_rdata,

    output logic                 mem_we,
    output logic [ADDR_W-1:0]    mem_a,
    output logic [WORD_SIZE-1:0] mem_din,
    input  logic [WORD_SIZE-1:0] mem_dout
);

    logic rd_pend;
    logic rd_tag;

`ifdef MEM_ARBITER_FIXED_PRIO_EN

    // Port 0 always wins; port 1 only gets the RAM when port 0 is idle.
    always_comb begin
        m0_gnt = 1'b0;
        m1_gnt = 1'b0;
        if (rst_n) begin
            m0_gnt = m0_req;
            m1_gnt = m1_req && !m0_req;
        end
    end

`else

    logic prio;

    // Round-robin pointer: after serving port k, favour the other port.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prio <= 1'b0;
        end else if (m0_gnt) begin
            prio <= 1'b1;
        end else if (m1_gnt) begin
            prio <= 1'b0;
        end
    end

    // A lone requester always wins; on conflict the favoured port wins.
    always_comb begin
        m0_gnt = 1'b0;
        m1_gnt = 1'b0;
        if (rst_n) begin
            if (m0_req && m1_req) begin
                m0_gnt = !prio;
                m1_gnt = prio;
            end else begin
                m0_gnt = m0_req;
                m1_gnt = m1_req;
            end
        end
    end

`endif

    // Only the granted port reaches the RAM, so no same-cycle read/write
    // conflict is possible. With no grant the bus is parked at zero.
    always_comb begin
        mem_we  = 1'b0;
        mem_a   = '0;
        mem_din = '0;
        if (m0_gnt) begin
            mem_we  = m0_we;
            mem_a   = m0_addr;
            mem_din = m0_wdata;
        end else if (m1_gnt) begin
            mem_we  = m1_we;
            mem_a   = m1_addr;
            mem_din = m1_wdata;
        end
    end

    // Remember that a read went to the RAM this cycle, and which port owns
    // it. The RAM output is valid exactly one cycle later. Reset drops any
    // read that is in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_pend <= 1'b0;
            rd_tag  <= 1'b0;
        end else begin
            rd_pend <= (m0_gnt && !m0_we) || (m1_gnt && !m1_we);
            rd_tag  <= m1_gnt;
        end
    end

    // Read data is passed straight through from the RAM. Each port sees it
    // only while it owns the return, so both rdata buses are 0 otherwise.
    always_comb begin
        m0_rvalid = rst_n && rd_pend && !rd_tag;
        m1_rvalid = rst_n && rd_pend &&  rd_tag;
        m0_rdata  = m0_rvalid ? mem_dout : '0;
        m1_rdata  = m1_rvalid ? mem_dout : '0;
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
// -----------------------------------------------------------------------------
// Directed testbench for mem_arbiter. A behavioural model of the sample RAM
// (24-bit x 512, 1-cycle registered read, old-data read-during-write) sits on
// the memory side. A preload port on that model seeds known words.
// Honours MEM_ARBITER_FIXED_PRIO_EN for the contention expectations.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

    localparam int WORD_SIZE = 24;
    localparam int N_WORDS   = 512;
    localparam int ADDR_W    = 9;

`ifdef MEM_ARBITER_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic                 clk;
    logic                 rst_n;
    logic                 m0_req, m0_we, m0_gnt, m0_rvalid;
    logic [ADDR_W-1:0]    m0_addr;
    logic [WORD_SIZE-1:0] m0_wdata, m0_rdata;
    logic                 m1_req, m1_we, m1_gnt, m1_rvalid;
    logic [ADDR_W-1:0]    m1_addr;
    logic [WORD_SIZE-1:0] m1_wdata, m1_rdata;
    logic                 mem_we;
    logic [ADDR_W-1:0]    mem_a;
    logic [WORD_SIZE-1:0] mem_din, mem_dout;

    logic                 pre_we;
    logic [ADDR_W-1:0]    pre_a;
    logic [WORD_SIZE-1:0] pre_d;
    logic [WORD_SIZE-1:0] ram [0:N_WORDS-1];

    int total;
    int bad;

    mem_arbiter #(.WORD_SIZE(WORD_SIZE), .N_WORDS(N_WORDS)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .mem_we(mem_we), .mem_a(mem_a), .mem_din(mem_din), .mem_dout(mem_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Sample RAM model: registered read of the old contents, plus preload.
    always @(posedge clk) begin
        mem_dout <= ram[mem_a];
        if (mem_we) ram[mem_a] <= mem_din;
        if (pre_we) ram[pre_a] <= pre_d;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired got=running want=finished");
        $fatal(1, "[TB] watchdog");
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        m0_req = 1'b0; m0_we = 1'b0; m0_addr = '0; m0_wdata = '0;
        m1_req = 1'b0; m1_we = 1'b0; m1_addr = '0; m1_wdata = '0;
    endtask

    task automatic preload(input logic [ADDR_W-1:0] a, input logic [WORD_SIZE-1:0] d);
        pre_we = 1'b1; pre_a = a; pre_d = d;
        next_cycle();
        pre_we = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        next_cycle();
        next_cycle();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        m0_req = 1'b1; m0_addr = 9'h000;
        m1_req = 1'b1; m1_addr = 9'h020;
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            #1;
            total++; if (m0_gnt !== 1'b0 || m1_gnt !== 1'b0) begin bad++; $display("[TB] FAIL reset_gnt[%0d] got=%b%b want=00", i, m0_gnt, m1_gnt); end
            total++; if (mem_we !== 1'b0) begin bad++; $display("[TB] FAIL reset_mem_we[%0d] got=%b want=0", i, mem_we); end
            total++; if (m0_rvalid !== 1'b0 || m1_rvalid !== 1'b0) begin bad++; $display("[TB] FAIL reset_rvalid[%0d] got=%b%b want=00", i, m0_rvalid, m1_rvalid); end
            total++; if (m0_rdata !== 24'h0 || m1_rdata !== 24'h0) begin bad++; $display("[TB] FAIL reset_rdata[%0d] got=%h/%h want=0/0", i, m0_rdata, m1_rdata); end
        end
        next_cycle();
        rst_n = 1'b1;
        #1;
        total++; if (m0_gnt !== 1'b1 || m1_gnt !== 1'b0) begin bad++; $display("[TB] FAIL release_gnt got=%b%b want=10", m0_gnt, m1_gnt); end
        total++; if (m0_rvalid !== 1'b0 || m1_rvalid !== 1'b0) begin bad++; $display("[TB] FAIL release_rvalid got=%b%b want=00", m0_rvalid, m1_rvalid); end
        next_cycle();
        idle_inputs();
        #1;
        total++; if (m0_rvalid !== 1'b1 || m0_rdata !== 24'h0A0A0A) begin bad++; $display("[TB] FAIL release_return got=%b/%h want=1/0a0a0a", m0_rvalid, m0_rdata); end
        next_cycle();
    endtask

    task automatic test_single_read();
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 9'h005;
        #1;
        total++; if (m0_gnt !== 1'b1 || mem_a !== 9'h005 || mem_we !== 1'b0) begin bad++; $display("[TB] FAIL single_grant got=%b/%h/%b want=1/005/0", m0_gnt, mem_a, mem_we); end
        next_cycle();
        idle_inputs();
        #1;
        total++; if (m0_rvalid !== 1'b1 || m0_rdata !== 24'hABCDEF) begin bad++; $display("[TB] FAIL single_return got=%b/%h want=1/abcdef", m0_rvalid, m0_rdata); end
        total++; if (m1_rvalid !== 1'b0 || m1_rdata !== 24'h0) begin bad++; $display("[TB] FAIL single_other got=%b/%h want=0/0", m1_rvalid, m1_rdata); end
        next_cycle();
        #1;
        total++; if (m0_rvalid !== 1'b0 || m0_rdata !== 24'h0) begin bad++; $display("[TB] FAIL single_once got=%b/%h want=0/0", m0_rvalid, m0_rdata); end
    endtask

    task automatic test_write_then_read();
        next_cycle();
        m1_req = 1'b1; m1_we = 1'b1; m1_addr = 9'h1FF; m1_wdata = 24'h123456;
        #1;
        total++; if (m1_gnt !== 1'b1 || m0_gnt !== 1'b0) begin bad++; $display("[TB] FAIL wr_grant got=%b%b want=01", m0_gnt, m1_gnt); end
        total++; if (mem_we !== 1'b1 || mem_a !== 9'h1FF || mem_din !== 24'h123456) begin bad++; $display("[TB] FAIL wr_bus got=%b/%h/%h want=1/1ff/123456", mem_we, mem_a, mem_din); end
        next_cycle();
        idle_inputs();
        m0_req = 1'b1; m0_addr = 9'h1FF;
        #1;
        total++; if (m0_gnt !== 1'b1) begin bad++; $display("[TB] FAIL rd_after_wr_grant got=%b want=1", m0_gnt); end
        total++; if (m1_rvalid !== 1'b0) begin bad++; $display("[TB] FAIL wr_no_rvalid got=%b want=0", m1_rvalid); end
        next_cycle();
        idle_inputs();
        #1;
        total++; if (m0_rvalid !== 1'b1 || m0_rdata !== 24'h123456) begin bad++; $display("[TB] FAIL rd_after_wr_data got=%b/%h want=1/123456", m0_rvalid, m0_rdata); end
    endtask

    task automatic test_back_to_back();
        next_cycle();
        for (int i = 0; i < 5; i++) begin
            if (i > 0) next_cycle();
            idle_inputs();
            if (i < 4) begin
                m0_req = 1'b1; m0_addr = 9'h030 + 9'(i);
            end
            #1;
            total++; if (m0_gnt !== (i < 4)) begin bad++; $display("[TB] FAIL b2b_gnt[%0d] got=%b want=%b", i, m0_gnt, (i < 4)); end
            if (i > 0) begin
                total++; if (m0_rvalid !== 1'b1 || m0_rdata !== 24'h333030 + 24'(i - 1)) begin bad++; $display("[TB] FAIL b2b_data[%0d] got=%b/%h want=1/%h", i, m0_rvalid, m0_rdata, 24'h333030 + 24'(i - 1)); end
            end
        end
    endtask

    task automatic test_contention();
        logic                 e0, e1, prev1;
        logic [WORD_SIZE-1:0] er0, er1;
        do_reset();
        for (int i = 0; i < 7; i++) begin
            if (i > 0) next_cycle();
            idle_inputs();
            if (i < 6) begin
                m0_req = 1'b1; m0_addr = 9'h010;
                m1_req = 1'b1; m1_addr = 9'h020;
            end
            #1;
            e1 = (i < 6) && !FIXED && (i % 2 == 1);
            e0 = (i < 6) && !e1;
            total++; if (m0_gnt !== e0 || m1_gnt !== e1) begin bad++; $display("[TB] FAIL cont_gnt[%0d] got=%b%b want=%b%b", i, m0_gnt, m1_gnt, e0, e1); end
            prev1 = !FIXED && ((i - 1) % 2 == 1);
            er0 = (i > 0 && !prev1) ? 24'h111010 : 24'h0;
            er1 = (i > 0 &&  prev1) ? 24'h222020 : 24'h0;
            total++; if (m0_rvalid !== (i > 0 && !prev1) || m0_rdata !== er0) begin bad++; $display("[TB] FAIL cont_ret0[%0d] got=%b/%h want=%b/%h", i, m0_rvalid, m0_rdata, (i > 0 && !prev1), er0); end
            total++; if (m1_rvalid !== (i > 0 && prev1) || m1_rdata !== er1) begin bad++; $display("[TB] FAIL cont_ret1[%0d] got=%b/%h want=%b/%h", i, m1_rvalid, m1_rdata, (i > 0 && prev1), er1); end
        end
    endtask

    task automatic test_reset_mid_read();
        next_cycle();
        idle_inputs();
        m0_req = 1'b1; m0_addr = 9'h005;
        #1;
        total++; if (m0_gnt !== 1'b1) begin bad++; $display("[TB] FAIL mid0_grant got=%b want=1", m0_gnt); end
        rst_n = 1'b0;
        next_cycle();
        rst_n = 1'b1;
        m0_req = 1'b1; m0_addr = 9'h005;
        m1_req = 1'b1; m1_addr = 9'h020;
        #1;
        total++; if (m0_rvalid !== 1'b0 || m0_rdata !== 24'h0) begin bad++; $display("[TB] FAIL mid0_discard got=%b/%h want=0/0", m0_rvalid, m0_rdata); end
        total++; if (m0_gnt !== 1'b1 || m1_gnt !== 1'b0) begin bad++; $display("[TB] FAIL mid0_prio got=%b%b want=10", m0_gnt, m1_gnt); end
        next_cycle();
        idle_inputs();
        m1_req = 1'b1; m1_addr = 9'h020;
        #1;
        total++; if (m1_gnt !== 1'b1) begin bad++; $display("[TB] FAIL mid1_grant got=%b want=1", m1_gnt); end
        total++; if (m0_rvalid !== 1'b1 || m0_rdata !== 24'hABCDEF) begin bad++; $display("[TB] FAIL mid0_return got=%b/%h want=1/abcdef", m0_rvalid, m0_rdata); end
        rst_n = 1'b0;
        next_cycle();
        rst_n = 1'b1;
        m0_req = 1'b1; m0_addr = 9'h005;
        m1_req = 1'b1; m1_addr = 9'h020;
        #1;
        total++; if (m1_rvalid !== 1'b0 || m1_rdata !== 24'h0) begin bad++; $display("[TB] FAIL mid1_discard got=%b/%h want=0/0", m1_rvalid, m1_rdata); end
        total++; if (m0_gnt !== 1'b1 || m1_gnt !== 1'b0) begin bad++; $display("[TB] FAIL mid1_prio got=%b%b want=10", m0_gnt, m1_gnt); end
        next_cycle();
        idle_inputs();
        #1;
        total++; if (m0_rvalid !== 1'b1 || m0_rdata !== 24'hABCDEF) begin bad++; $display("[TB] FAIL mid1_after got=%b/%h want=1/abcdef", m0_rvalid, m0_rdata); end
        next_cycle();
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        pre_we = 1'b0; pre_a = '0; pre_d = '0;
        idle_inputs();
        next_cycle();
        preload(9'h000, 24'h0A0A0A);
        preload(9'h005, 24'hABCDEF);
        preload(9'h010, 24'h111010);
        preload(9'h020, 24'h222020);
        for (int i = 0; i < 4; i++) preload(9'h030 + 9'(i), 24'h333030 + 24'(i));

        test_reset();
        test_single_read();
        test_write_then_read();
        test_back_to_back();
        test_contention();
        test_reset_mid_read();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
